dest_fifo_reader: RTL

Consumer side of the destination FIFOs (D0/D1) in the QoS datapath. It drains two destination FIFOs with weighted round-robin, issuing fifo_rd pulses and capturing popped words. Output is a single valid-qualified stream tagged with its source FIFO. It honours a downstream pause and never reads an empty FIFO.

---
 rtl/dest_fifo_reader_pkg.sv | 21 ++
 rtl/dest_fifo_reader_if.sv | 30 +++
 rtl/dest_fifo_reader.sv | 114 +++++++++++
 3 files changed

// File: rtl/dest_fifo_reader_pkg.sv
// Shared encodings for the destination FIFO reader: FSM states and source IDs.
package dest_fifo_reader_pkg;

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] SERVE0 = 2'd1;
    localparam logic [1:0] SERVE1 = 2'd2;

    localparam logic SRC_D0 = 1'b0;
    localparam logic SRC_D1 = 1'b1;

    typedef enum logic [1:0] {
        StIdle   = IDLE,
        StServe0 = SERVE0,
        StServe1 = SERVE1
    } state_e;

    function automatic state_e serve_state(input logic src);
        return (src == SRC_D1) ? StServe1 : StServe0;
    endfunction

endpackage

// File: rtl/dest_fifo_reader_if.sv
// Bundle between the two destination FIFOs, the reader and its downstream consumer.
interface dest_fifo_reader_if #(
    parameter int unsigned BW = 6
);

    logic          D0_empty;
    logic [BW-1:0] D0_data_out;
    logic          D0_rd;
    logic          D1_empty;
    logic [BW-1:0] D1_data_out;
    logic          D1_rd;
    logic          pause;
    logic [BW-1:0] data_out;
    logic          valid_out;
    logic          src_out;
    logic          idle;

    // Reader side.
    modport master (
        input  D0_empty, D0_data_out, D1_empty, D1_data_out, pause,
        output D0_rd, D1_rd, data_out, valid_out, src_out, idle
    );

    // FIFO / downstream side.
    modport slave (
        output D0_empty, D0_data_out, D1_empty, D1_data_out, pause,
        input  D0_rd, D1_rd, data_out, valid_out, src_out, idle
    );

endinterface

// File: rtl/dest_fifo_reader.sv
// Drains destination FIFOs D0/D1 with weighted round-robin (up to BURST reads per turn)
// and emits each popped word, tagged with its source, two cycles after the pop strobe.
module dest_fifo_reader
    import dest_fifo_reader_pkg::*;
#(
    parameter int unsigned BW    = 6,
    parameter int unsigned BURST = 4
) (
    input  logic               clk,
    input  logic               reset,
    dest_fifo_reader_if.master bus
);

    localparam logic [3:0] BurstMax = 4'(BURST);

    state_e        state_q, state_d;
    logic          rr_q, rr_d;
    logic [3:0]    burst_q, burst_d;
    logic [3:0]    burst_inc;
    logic          rd_q, rd_src_q;
    logic [BW-1:0] data_q;
    logic          valid_q;
    logic          src_q;

    logic          serving;
    logic          cur_src;
    logic          cur_empty;
    logic          oth_empty;
    logic          rd;

    always_comb begin
        serving   = (state_q != StIdle);
        cur_src   = (state_q == StServe1) ? SRC_D1 : SRC_D0;
        cur_empty = (cur_src == SRC_D1) ? bus.D1_empty : bus.D0_empty;
        oth_empty = (cur_src == SRC_D1) ? bus.D0_empty : bus.D1_empty;
        // Empty is sampled in the same cycle as the strobe, so an empty FIFO is never popped.
        rd        = serving & ~cur_empty & ~bus.pause & (burst_q < BurstMax);
        burst_inc = burst_q + 4'(rd);

        state_d = state_q;
        rr_d    = rr_q;
        burst_d = burst_inc;

        unique case (state_q)
            StIdle: begin
                burst_d = '0;
                if (!bus.D0_empty && !bus.D1_empty) begin
                    state_d = serve_state(rr_q);
                end else if (!bus.D0_empty) begin
                    state_d = StServe0;
                end else if (!bus.D1_empty) begin
                    state_d = StServe1;
                end
            end
            StServe0, StServe1: begin
                if (cur_empty || (burst_inc == BurstMax) || bus.pause) begin
                    if (bus.pause) begin
                        burst_d = burst_q;
                    end else if (!oth_empty) begin
                        state_d = serve_state(~cur_src);
                        burst_d = '0;
                        rr_d    = ~cur_src;
                    end else if (!cur_empty) begin
                        // Burst spent but nobody else waiting: start a fresh burst.
                        burst_d = '0;
                    end else begin
                        state_d = StIdle;
                        burst_d = '0;
                        rr_d    = ~cur_src;
                    end
                end
            end
            default: begin
                state_d = StIdle;
                burst_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= StIdle;
            rr_q     <= SRC_D0;
            burst_q  <= '0;
            rd_q     <= 1'b0;
            rd_src_q <= SRC_D0;
            data_q   <= '0;
            valid_q  <= 1'b0;
            src_q    <= SRC_D0;
        end else begin
            state_q  <= state_d;
            rr_q     <= rr_d;
            burst_q  <= burst_d;
            rd_q     <= rd;
            rd_src_q <= cur_src;
            valid_q  <= rd_q;
            // FIFO read data is valid the cycle after the strobe; capture it then.
            if (rd_q) begin
                data_q <= (rd_src_q == SRC_D1) ? bus.D1_data_out : bus.D0_data_out;
                src_q  <= rd_src_q;
            end
        end
    end

    always_comb begin
        bus.D0_rd     = rd & (cur_src == SRC_D0);
        bus.D1_rd     = rd & (cur_src == SRC_D1);
        bus.data_out  = data_q;
        bus.valid_out = valid_q;
        bus.src_out   = src_q;
        bus.idle      = (state_q == StIdle) & ~rd_q & ~valid_q;
    end

endmodule
